kernel_fetch_ctrl: RTL
======================

Name: kernel_fetch_ctrl

Overview:
Controller that owns the single-port kernel weight BRAM and sequences both of its uses.
- Load path: streams a full kernel set from the config interface into consecutive addresses.
- Fetch path: reads the KERNEL_SIZE² weight words of one input channel and presents them to the convolution engine as a valid/ready stream.
- Arbitrates the two paths so only one owns the BRAM at a time.

Parameters:
KERNEL_WEIGHT_BITS, 6, bits per weight
KERNEL_SIZE, 3, kernel side length K
IN_CHANNELS, 6, number of input channels
OUT_CHANNELS, 6, weights packed per BRAM word
DATA_WIDTH, KERNEL_WEIGHT_BITS*OUT_CHANNELS, BRAM word width
TOTAL_KERNEL_POSITIONS, IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE, number of words loaded/addressable
ADDR_WIDTH, $clog2(TOTAL_KERNEL_POSITIONS), BRAM address width
POS_WIDTH, $clog2(KERNEL_SIZE*KERNEL_SIZE), kernel position index width
CH_WIDTH, $clog2(IN_CHANNELS) (min 1), channel index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
load_start  in  1  request a full kernel load
fetch_start  in  1  request a fetch of channel fetch_ch
fetch_ch  in  CH_WIDTH  channel to fetch, sampled when fetch_start is accepted
start_ready  out  1  controller is idle; start requests are accepted this cycle
wr_valid  in  1  load data beat valid
wr_ready  out  1  load data beat accepted
wr_data  in  DATA_WIDTH  load data beat
w_valid  out  1  weight word valid
w_ready  in  1  engine accepts weight word
w_data  out  DATA_WIDTH  weight word (driven directly from bram_dout)
w_pos  out  POS_WIDTH  kernel position 0..K²-1 of w_data
w_last  out  1  w_data is position K²-1
load_done  out  1  one-cycle pulse, load complete
fetch_done  out  1  one-cycle pulse, fetch complete
cmd_err  out  1  one-cycle pulse, fetch_start rejected (fetch_ch ≥ IN_CHANNELS)
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_WIDTH  BRAM address
bram_din  out  DATA_WIDTH  BRAM write data
bram_dout  in  DATA_WIDTH  BRAM read data; 1-cycle latency, holds value while bram_en=0

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; address and position counters clear to 0.
  - All outputs go to 0 except start_ready=1.
  - BRAM contents are not touched.
  - Reset mid-load or mid-fetch aborts the operation; no done pulse is issued.
- States: IDLE, LOAD, FETCH, DRAIN.
- IDLE:
  - start_ready=1; bram_en=0.
  - load_start=1 → LOAD with addr=0.
  - Else fetch_start=1 with fetch_ch<IN_CHANNELS → FETCH with base=fetch_ch*K², pos=0.
  - Else fetch_start=1 with fetch_ch≥IN_CHANNELS → cmd_err pulse next cycle; remain IDLE.
  - Simultaneous load_start and fetch_start: load wins; the fetch request is dropped.
- LOAD:
  - wr_ready=1.
  - Each wr_valid beat: bram_en=1, bram_we=1, bram_addr=addr, bram_din=wr_data; addr increments.
  - Beat at addr=TOTAL_KERNEL_POSITIONS-1 → load_done pulse next cycle; go to IDLE.
  - Gaps in wr_valid are allowed: bram_en=0 on those cycles.
- FETCH:
  - Issue condition: issue = !w_valid || w_ready.
  - On issue: bram_en=1, bram_we=0, bram_addr=base+pos.
  - Next cycle: w_valid=1, w_pos=pos, w_last=(pos==K²-1).
  - When not issuing, bram_en=0, so bram_dout and w_data hold under backpressure.
  - Throughput is 1 word/cycle when w_ready=1.
  - After the issue with pos=K²-1 → DRAIN.
- DRAIN:
  - No issues.
  - When the word with w_last=1 is accepted (w_valid && w_ready): w_valid=0, fetch_done pulse next cycle, go to IDLE.
- Latency: fetch_start accepted in cycle 0 → first w_valid in cycle 2 (with w_ready=1).
- w_valid, once high, stays high with stable w_data/w_pos/w_last until accepted.
- wr_data is never written outside LOAD; bram_we=0 outside LOAD.
- Start requests arriving outside IDLE are ignored (start_ready=0); cmd_err is not raised for them.

Test Plan:
1. Load TOTAL_KERNEL_POSITIONS=54 beats, data=addr+0x100, wr_valid continuous → 54 writes to addrs 0..53, load_done pulse one cycle after beat 53, start_ready high the following cycle.
2. After load, fetch_ch=2 with w_ready=1 → bram_addr 18..26 on consecutive cycles; 9 beats with w_data=0x112..0x11A, w_pos 0..8, w_last only on pos 8; first w_valid 2 cycles after accept; fetch_done one cycle after the last beat.
3. fetch_ch=5 with w_ready toggling 1,0,0,1,… → w_data stable through each stall, no duplicate or missing positions, words 0x12D..0x135 in order, bram_en=0 on every stall cycle.
4. load_start and fetch_start asserted in the same IDLE cycle → LOAD entered, no read issued, no fetch_done.
5. fetch_ch=6 → cmd_err pulse, no bram_en, stays IDLE. fetch_start asserted during LOAD → ignored.
6. rst asserted after 4 fetch beats → all outputs 0 immediately; after release, fetch ch 0 returns 0x100..0x108, showing BRAM contents are intact.

Source files
------------

// File: rtl/kernel_fetch_ctrl.sv
// Kernel weight BRAM owner: streams a full kernel set in (LOAD) and reads one
// input channel's K*K words back out as a valid/ready stream (FETCH/DRAIN).
module kernel_fetch_ctrl #(
  parameter int KERNEL_WEIGHT_BITS     = 6,
  parameter int KERNEL_SIZE            = 3,
  parameter int IN_CHANNELS            = 6,
  parameter int OUT_CHANNELS           = 6,
  parameter int DATA_WIDTH             = KERNEL_WEIGHT_BITS*OUT_CHANNELS,
  parameter int TOTAL_KERNEL_POSITIONS = IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE,
  parameter int ADDR_WIDTH             = $clog2(TOTAL_KERNEL_POSITIONS),
  parameter int POS_WIDTH              = $clog2(KERNEL_SIZE*KERNEL_SIZE),
  parameter int CH_WIDTH               = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  fetch_start,
  input  logic [CH_WIDTH-1:0]   fetch_ch,
  output logic                  start_ready,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [POS_WIDTH-1:0]  w_pos,
  output logic                  w_last,
  output logic                  load_done,
  output logic                  fetch_done,
  output logic                  cmd_err,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam int KK = KERNEL_SIZE*KERNEL_SIZE;
  localparam logic [POS_WIDTH-1:0]  POS_LAST  = POS_WIDTH'(KK-1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(TOTAL_KERNEL_POSITIONS-1);
  localparam logic [ADDR_WIDTH-1:0] KK_A      = ADDR_WIDTH'(KK);
  localparam logic [CH_WIDTH:0]     CH_LIM    = (CH_WIDTH+1)'(IN_CHANNELS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [POS_WIDTH-1:0]  pos_q, pos_d;
  logic                  w_valid_q, w_valid_d;
  logic [POS_WIDTH-1:0]  w_pos_q, w_pos_d;
  logic                  w_last_q, w_last_d;
  logic                  load_done_q, load_done_d;
  logic                  fetch_done_q, fetch_done_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  issue;

  assign start_ready = (state_q == S_IDLE);
  assign wr_ready    = (state_q == S_LOAD);
  assign w_valid     = w_valid_q;
  assign w_pos       = w_pos_q;
  assign w_last      = w_last_q;
  assign load_done   = load_done_q;
  assign fetch_done  = fetch_done_q;
  assign cmd_err     = cmd_err_q;
  // w_data holds under backpressure because the BRAM is not re-enabled while stalled
  assign w_data      = bram_dout;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    base_d       = base_q;
    pos_d        = pos_q;
    w_valid_d    = w_valid_q;
    w_pos_d      = w_pos_q;
    w_last_d     = w_last_q;
    load_done_d  = 1'b0;
    fetch_done_d = 1'b0;
    cmd_err_d    = 1'b0;
    issue        = 1'b0;
    bram_en      = 1'b0;
    bram_we      = 1'b0;
    bram_addr    = '0;
    bram_din     = '0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          addr_d  = '0;
        end else if (fetch_start) begin
          if ({1'b0, fetch_ch} < CH_LIM) begin
            state_d = S_FETCH;
            base_d  = ADDR_WIDTH'(fetch_ch) * KK_A;
            pos_d   = '0;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (wr_valid) begin
          bram_en   = 1'b1;
          bram_we   = 1'b1;
          bram_addr = addr_q;
          bram_din  = wr_data;
          if (addr_q == ADDR_LAST) begin
            load_done_d = 1'b1;
            addr_d      = '0;
            state_d     = S_IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_FETCH: begin
        // read the next word only when the output register is free or being drained
        issue = !w_valid_q || w_ready;
        if (issue) begin
          bram_en   = 1'b1;
          bram_addr = base_q + ADDR_WIDTH'(pos_q);
          w_valid_d = 1'b1;
          w_pos_d   = pos_q;
          w_last_d  = (pos_q == POS_LAST);
          if (pos_q == POS_LAST) begin
            pos_d   = '0;
            state_d = S_DRAIN;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_valid_q && w_ready) begin
          w_valid_d    = 1'b0;
          w_pos_d      = '0;
          w_last_d     = 1'b0;
          fetch_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      base_q       <= '0;
      pos_q        <= '0;
      w_valid_q    <= 1'b0;
      w_pos_q      <= '0;
      w_last_q     <= 1'b0;
      load_done_q  <= 1'b0;
      fetch_done_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      pos_q        <= pos_d;
      w_valid_q    <= w_valid_d;
      w_pos_q      <= w_pos_d;
      w_last_q     <= w_last_d;
      load_done_q  <= load_done_d;
      fetch_done_q <= fetch_done_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

endmodule
